// File: rtl/gsim_pkg.sv
// Shared definitions for the Gauss-Seidel solver: state encoding and the
// fixed stencil/divisor constants of the update rule.
package gsim_pkg;

    typedef enum logic [1:0] {
        ST_RECV = 2'd0,
        ST_CALC = 2'd1,
        ST_SEND = 2'd2
    } gsim_state_e;

    localparam int C_NEAR  = 13;
    localparam int C_MID   = 6;
    localparam int C_FAR   = 1;
    localparam int C_DIV   = 20;
    localparam int DIV_LAT = 3;
    localparam int UPD_CYC = 5;

endpackage

// File: rtl/gsim_div20.sv
// Fixed-latency (3 cycle) signed floor division by 20, built as
// floor(floor(n/4)/5) so only a divide-by-5 with sign correction remains.
module gsim_div20
    import gsim_pkg::*;
#(
    parameter int NW = 38,
    parameter int QW = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [NW-1:0] num_i,
    output logic signed [QW-1:0] quo_o
);

    localparam logic signed [NW-1:0] DIV5 = NW'(C_DIV / 4);

    logic signed [NW-1:0] q4_q;
    logic signed [NW-1:0] q5_q;
    logic                 adj_q;
    logic signed [NW-1:0] q5_s;
    logic signed [NW-1:0] r5_s;
    logic        [NW-1:0] fl_s;

    // Truncating divide; a nonzero remainder on a negative value needs one step down.
    always_comb begin
        q5_s = q4_q / DIV5;
        r5_s = q4_q % DIV5;
        fl_s = q5_q - {{(NW-1){1'b0}}, adj_q};
    end

    // Three pipeline stages: arithmetic shift, divide-by-5, floor correction.
    always_ff @(posedge clk) begin
        if (reset) begin
            q4_q  <= '0;
            q5_q  <= '0;
            adj_q <= 1'b0;
            quo_o <= '0;
        end else begin
            q4_q  <= num_i >>> 2;
            q5_q  <= q5_s;
            adj_q <= (r5_s != '0) && q4_q[NW-1];
            quo_o <= fl_s[QW-1:0];
        end
    end

endmodule

// File: rtl/gsim_param.sv
// Gauss-Seidel solver for a 7-band stencil system: receives b, runs a
// programmable number of sweeps, then streams x out with ready/valid.
module gsim_param
    import gsim_pkg::*;
#(
    parameter int N    = 16,
    parameter int B_W  = 16,
    parameter int FRAC = 16,
    parameter int IT_W = 8,
    localparam int X_W = B_W + FRAC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_en,
    output logic                  in_ready,
    input  logic signed [B_W-1:0] b_in,
    input  logic [IT_W-1:0]       iter_cfg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [X_W-1:0] x_out,
    output logic                  busy
);

    localparam int IDX_W = $clog2(N);
    localparam int NW    = X_W + 6;
    localparam logic [2:0] PH_LAST = 3'(UPD_CYC - 1);
    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N - 1);

    gsim_state_e state_q, state_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic [2:0]       ph_q, ph_d;
    logic [IT_W-1:0]  sw_q, sw_d, iter_q, iter_d;
    logic signed [X_W-1:0] xo_q, xo_d;
    logic ir_q, ir_d, ov_q, ov_d, bz_q, bz_d;

    logic signed [B_W-1:0] b_mem [N];
    logic signed [X_W-1:0] x_mem [N];

    logic signed [X_W-1:0] xl_s [1:3];
    logic signed [X_W-1:0] xr_s [1:3];
    logic signed [NW-1:0]  s1_s, s2_s, s3_s, bsh_s, num_s, num_q;
    logic signed [X_W-1:0] quo_s;
    logic last_k_s, recv_we_s, calc_we_s;

    function automatic logic signed [NW-1:0] sext(input logic signed [X_W-1:0] v);
        return {{(NW-X_W){v[X_W-1]}}, v};
    endfunction

    assign last_k_s  = (k_q == K_LAST);
    assign recv_we_s = (state_q == ST_RECV) && in_en;
    assign calc_we_s = (state_q == ST_CALC) && (iter_q != '0) && (ph_q == PH_LAST);

    // Neighbour fetch; indices outside 0..N-1 contribute zero.
    always_comb begin
        for (int d = 1; d <= 3; d++) begin
            if (int'(k_q) >= d) xl_s[d] = x_mem[k_q - IDX_W'(d)];
            else                xl_s[d] = '0;
            if (int'(k_q) + d < N) xr_s[d] = x_mem[k_q + IDX_W'(d)];
            else                   xr_s[d] = '0;
        end
    end

    // Numerator as shift-add: 13 = 8+4+1, 6 = 4+2; valid in phase 0 of each update.
    always_comb begin
        s1_s  = sext(xl_s[1]) + sext(xr_s[1]);
        s2_s  = sext(xl_s[2]) + sext(xr_s[2]);
        s3_s  = sext(xl_s[3]) + sext(xr_s[3]);
        bsh_s = {{(NW-X_W){b_mem[k_q][B_W-1]}}, b_mem[k_q], {FRAC{1'b0}}};
        num_s = bsh_s + (s1_s <<< 3) + (s1_s <<< 2) + s1_s
              - ((s2_s <<< 2) + (s2_s <<< 1)) + s3_s;
    end

    gsim_div20 #(.NW(NW), .QW(X_W)) u_div (
        .clk   (clk),
        .reset (reset),
        .num_i (num_q),
        .quo_o (quo_s)
    );

    // Next-state logic: receive counter, sweep/phase sequencing, output stepping.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        ph_d    = ph_q;
        sw_d    = sw_q;
        iter_d  = iter_q;
        xo_d    = xo_q;
        case (state_q)
            ST_RECV: begin
                if (in_en) begin
                    if (k_q == '0) iter_d = iter_cfg;
                    else           iter_d = iter_q;
                    if (last_k_s) begin
                        state_d = ST_CALC;
                        k_d     = '0;
                        ph_d    = 3'd0;
                        sw_d    = '0;
                    end else begin
                        k_d = k_q + IDX_W'(1);
                    end
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_CALC: begin
                if (iter_q == '0) begin
                    state_d = ST_SEND;
                    k_d     = '0;
                    xo_d    = x_mem[0];
                end else if (ph_q == PH_LAST) begin
                    ph_d = 3'd0;
                    if (last_k_s) begin
                        k_d = '0;
                        if (sw_q == iter_q - IT_W'(1)) begin
                            state_d = ST_SEND;
                            xo_d    = x_mem[0];
                        end else begin
                            sw_d = sw_q + IT_W'(1);
                        end
                    end else begin
                        k_d = k_q + IDX_W'(1);
                    end
                end else begin
                    ph_d = ph_q + 3'd1;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (last_k_s) begin
                        state_d = ST_RECV;
                        k_d     = '0;
                        xo_d    = '0;
                    end else begin
                        k_d  = k_q + IDX_W'(1);
                        xo_d = x_mem[k_q + IDX_W'(1)];
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_RECV;
                k_d     = '0;
                ph_d    = 3'd0;
                sw_d    = '0;
                xo_d    = '0;
            end
        endcase
        ir_d = (state_d == ST_RECV);
        ov_d = (state_d == ST_SEND);
        bz_d = (state_d != ST_RECV);
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RECV;
            k_q     <= '0;
            ph_q    <= 3'd0;
            sw_q    <= '0;
            iter_q  <= '0;
            xo_q    <= '0;
            ir_q    <= 1'b1;
            ov_q    <= 1'b0;
            bz_q    <= 1'b0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            ph_q    <= ph_d;
            sw_q    <= sw_d;
            iter_q  <= iter_d;
            xo_q    <= xo_d;
            ir_q    <= ir_d;
            ov_q    <= ov_d;
            bz_q    <= bz_d;
            num_q   <= num_s;
        end
    end

    // Problem storage is deliberately unreset; RECV rewrites every entry.
    always_ff @(posedge clk) begin
        if (!reset && recv_we_s) begin
            b_mem[k_q] <= b_in;
            x_mem[k_q] <= {b_in, {FRAC{1'b0}}};
        end else if (!reset && calc_we_s) begin
            x_mem[k_q] <= quo_s;
        end
    end

    assign in_ready  = ir_q;
    assign out_valid = ov_q;
    assign x_out     = xo_q;
    assign busy      = bz_q;

endmodule

// File: tb/tb_gsim_param.sv
// Table-driven scoreboard bench for gsim_param at N=16, 4 and 64.
module tb_gsim_param;

    typedef struct {
        int sel;
        int n;
        int pat;
        int iter;
        bit rnd;
        bit chk_x0;
        int x0;
        int calc;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, in_en, out_ready;
    logic signed [15:0] b_in;
    logic [7:0] iter_cfg;
    int sel;
    logic [2:0] en_v, ord_v, ir_a, ov_a, bz_a;
    logic signed [31:0] x0_s, x1_s, x2_s;

    int total = 0;
    int bad = 0;
    int exp_q[$];
    vec_t tbl[8];

    assign en_v  = in_en     ? (3'b001 << sel) : 3'b000;
    assign ord_v = out_ready ? (3'b001 << sel) : 3'b000;

    gsim_param #(.N(16)) u_n16 (.clk(clk), .reset(reset), .in_en(en_v[0]), .in_ready(ir_a[0]),
        .b_in(b_in), .iter_cfg(iter_cfg), .out_valid(ov_a[0]), .out_ready(ord_v[0]),
        .x_out(x0_s), .busy(bz_a[0]));
    gsim_param #(.N(4)) u_n4 (.clk(clk), .reset(reset), .in_en(en_v[1]), .in_ready(ir_a[1]),
        .b_in(b_in), .iter_cfg(iter_cfg), .out_valid(ov_a[1]), .out_ready(ord_v[1]),
        .x_out(x1_s), .busy(bz_a[1]));
    gsim_param #(.N(64)) u_n64 (.clk(clk), .reset(reset), .in_en(en_v[2]), .in_ready(ir_a[2]),
        .b_in(b_in), .iter_cfg(iter_cfg), .out_valid(ov_a[2]), .out_ready(ord_v[2]),
        .x_out(x2_s), .busy(bz_a[2]));

    function automatic logic signed [31:0] cur_x(input int s);
        case (s)
            0:       return x0_s;
            1:       return x1_s;
            default: return x2_s;
        endcase
    endfunction

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    function automatic longint gx(input int x[64], input int j, input int n);
        if (j < 0 || j >= n) return 64'sd0;
        return longint'(x[j]);
    endfunction

    // Bit-exact reference: wide integer arithmetic, floor division, 32-bit wrap.
    function automatic void model(input int n, input int b[64], input int iter, output int x[64]);
        longint acc, q;
        for (int k = 0; k < 64; k++) x[k] = (k < n) ? b[k] * 65536 : 0;
        for (int s = 0; s < iter; s++) begin
            for (int i = 0; i < n; i++) begin
                acc = longint'(b[i]) * 65536
                    + 13 * (gx(x, i-1, n) + gx(x, i+1, n))
                    - 6  * (gx(x, i-2, n) + gx(x, i+2, n))
                    + (gx(x, i-3, n) + gx(x, i+3, n));
                q = acc / 20;
                if ((acc % 20) != 0 && acc < 0) q = q - 1;
                x[i] = int'(q);
            end
        end
    endfunction

    task automatic build_b(input int n, input int pat, output int b[64]);
        for (int k = 0; k < 64; k++) begin
            case (pat)
                0:       b[k] = 0;
                1:       b[k] = 20;
                2:       b[k] = (k == 0) ? 1 : 0;
                default: b[k] = int'($urandom_range(0, 65535)) - 32768;
            endcase
        end
    endtask

    task automatic drive(input int s, input int n, input int b[64], input int iter);
        int k = 0;
        int guard = 0;
        sel = s;
        while (k < n && guard < 2000) begin
            @(negedge clk);
            in_en = 1'b1;
            b_in = 16'(b[k]);
            iter_cfg = 8'(iter);
            if (ir_a[s]) k++;
            guard++;
        end
        if (k < n) chk("in_timeout", k, n);
    endtask

    task automatic collect(input int s, input int n, input int exp_calc, input bit rnd,
                           input bit chkx0, input int x0);
        int got = 0;
        int calc = 0;
        int cyc = 0;
        longint first = 0;
        bit held = 1'b0;
        logic signed [31:0] hv = '0;
        logic signed [31:0] xv;
        while (got < n && cyc < exp_calc + 40 * n + 100) begin
            @(negedge clk);
            in_en = 1'b0;
            cyc++;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            xv = cur_x(s);
            if (held) begin
                chk("stall_hold", xv, hv);
                chk("stall_valid", ov_a[s], 1);
                held = 1'b0;
            end
            if (bz_a[s] && !ov_a[s]) calc++;
            if (ov_a[s] && out_ready) begin
                if (got == 0) first = xv;
                if (exp_q.size() == 0) chk("queue_empty", 1, 0);
                else chk("x_out", xv, exp_q.pop_front());
                got++;
            end else if (ov_a[s]) begin
                held = 1'b1;
                hv = xv;
            end
        end
        if (got < n) chk("out_timeout", got, n);
        @(negedge clk);
        out_ready = 1'b0;
        chk("in_ready_after", ir_a[s], 1);
        chk("busy_after", bz_a[s], 0);
        chk("calc_cycles", calc, exp_calc);
        if (chkx0) chk("x0_value", first, x0);
        exp_q.delete();
    endtask

    task automatic run_vec(input vec_t v);
        int b[64];
        int x[64];
        build_b(v.n, v.pat, b);
        model(v.n, b, v.iter, x);
        for (int k = 0; k < v.n; k++) exp_q.push_back(x[k]);
        drive(v.sel, v.n, b, v.iter);
        collect(v.sel, v.n, v.calc, v.rnd, v.chk_x0, v.x0);
    endtask

    task automatic do_reset_check(input int s);
        @(negedge clk);
        in_en = 1'b0;
        out_ready = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", ir_a[s], 1);
        chk("rst_out_valid", ov_a[s], 0);
        chk("rst_busy", bz_a[s], 0);
        chk("rst_x_out", cur_x(s), 0);
        reset = 1'b0;
    endtask

    initial begin
        int b[64];
        int guard;
        vec_t v;
        reset = 1'b1;
        in_en = 1'b0;
        out_ready = 1'b0;
        b_in = '0;
        iter_cfg = '0;
        sel = 0;
        //          sel  n  pat iter rnd chk  x0      calc
        tbl[0] = '{0, 16, 0, 5,  1'b0, 1'b1, 0,      400};
        tbl[1] = '{0, 16, 1, 1,  1'b0, 1'b1, 589824, 80};
        tbl[2] = '{0, 16, 2, 0,  1'b0, 1'b1, 65536,  1};
        tbl[3] = '{0, 16, 3, 70, 1'b1, 1'b0, 0,      5600};
        tbl[4] = '{1, 4,  1, 1,  1'b0, 1'b1, 589824, 20};
        tbl[5] = '{2, 64, 1, 1,  1'b0, 1'b1, 589824, 320};
        tbl[6] = '{1, 4,  3, 3,  1'b1, 1'b0, 0,      60};
        tbl[7] = '{2, 64, 3, 2,  1'b1, 1'b0, 0,      640};

        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            chk("init_in_ready", ir_a[s], 1);
            chk("init_out_valid", ov_a[s], 0);
            chk("init_busy", bz_a[s], 0);
            chk("init_x_out", cur_x(s), 0);
        end
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // Abort in the middle of CALC, then a fresh problem.
        build_b(16, 3, b);
        drive(0, 16, b, 70);
        repeat (50) @(negedge clk);
        in_en = 1'b0;
        chk("abort_calc_busy", bz_a[0], 1);
        do_reset_check(0);
        v = '{0, 16, 3, 4, 1'b1, 1'b0, 0, 320};
        run_vec(v);

        // Abort in the middle of SEND, then a fresh problem.
        build_b(64, 1, b);
        drive(2, 64, b, 0);
        guard = 0;
        @(negedge clk);
        in_en = 1'b0;
        while (!ov_a[2] && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("abort_send_valid", ov_a[2], 1);
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        out_ready = 1'b0;
        do_reset_check(2);
        v = '{2, 64, 3, 1, 1'b0, 1'b0, 0, 320};
        run_vec(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gsim_param.md
GSIM_PARAM -- requirements
Module: gsim_param

Interface
REQ-001 Parameter N, default 16: number of unknowns; legal range 4..64.
REQ-002 Parameter B_W, default 16: signed width of each b element.
REQ-003 Parameter FRAC, default 16: fractional bits of x; X_W = B_W+FRAC, default 32.
REQ-004 Parameter IT_W, default 8: width of the runtime sweep count.
REQ-005 Port clk, input, 1: the single clock; all logic rising-edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port in_en, input, 1: b_in valid.
REQ-008 Port in_ready, output, 1: high only in RECV; a transfer occurs when in_en and in_ready are both high.
REQ-009 Port b_in, input, B_W, signed: b elements in index order 0..N-1.
REQ-010 Port iter_cfg, input, IT_W: sweep count, sampled with element 0 only.
REQ-011 Port out_valid, output, 1: x_out holds a valid result.
REQ-012 Port out_ready, input, 1: downstream accepts x_out.
REQ-013 Port x_out, output, X_W, signed: x elements in index order 0..N-1.
REQ-014 Port busy, output, 1: high in CALC and SEND.

Function
REQ-015 FSM states SHALL be RECV, CALC and SEND; RECV->CALC after element N-1 transfers; CALC->SEND after the last update; SEND->RECV after element N-1 transfers.
REQ-016 Each RECV transfer SHALL store b[k] and initialise x[k] = b[k] << FRAC, with k counting 0..N-1.
REQ-017 One sweep SHALL update x[0]..x[N-1] in order, and every update SHALL use the already-updated lower-index values (Gauss-Seidel).
REQ-018 Update rule: x[i] = floor((b[i]<<FRAC + 13(x[i-1]+x[i+1]) - 6(x[i-2]+x[i+2]) + (x[i-3]+x[i+3])) / 20).
REQ-019 Any term with an index outside 0..N-1 SHALL be zero.
REQ-020 The numerator SHALL be computed at X_W+6 bits; the quotient SHALL be exact floor division by 20, truncated to X_W bits with two's-complement wrap.
REQ-021 Each update SHALL take exactly 5 cycles, so CALC lasts iter_cfg*N*5 cycles.
REQ-022 If iter_cfg = 0, CALC SHALL last 1 cycle and the output SHALL equal the initial guess.
REQ-023 SEND SHALL present x[0] first; x_out advances only on out_valid && out_ready.
REQ-024 While out_ready is low, x_out and out_valid SHALL hold stable.
REQ-025 in_en SHALL be ignored outside RECV; out_ready SHALL be ignored outside SEND.
REQ-026 in_ready SHALL assert in the cycle after the last SEND transfer, so back-to-back problems are allowed.

Reset
REQ-027 While reset is high at a clock edge, the state SHALL become RECV and all counters SHALL clear.
REQ-028 After reset, outputs SHALL be: in_ready=1, out_valid=0, busy=0, x_out=0.
REQ-029 Reset SHALL abort an operation in any state, including mid-CALC and mid-SEND.
REQ-030 After an aborted operation, the next problem SHALL be processed correctly without relying on the contents of the b/x storage, which is not reset.

Structure
REQ-031 Shared package gsim_pkg SHALL hold the state encoding and the coefficient constants 13, 6, 1 and 20.
REQ-032 Sub-module gsim_div20 SHALL implement a fixed-latency, pipelined, exact signed floor division by 20.
REQ-033 The update datapath SHALL have exactly one sub-module instance, gsim_div20; the coefficient multiplies SHALL be shift-add.

Verification
REQ-034 N=16, all b=0, iter_cfg=5 -> 16 outputs, all 0; CALC lasts 400 cycles.
REQ-035 N=16, all b=20, iter_cfg=1 -> x_out[0] = 589824 (0x00090000), matching the bit-exact model for all 16 elements.
REQ-036 N=16, b[0]=1 and others 0, iter_cfg=0 -> x_out[0]=0x00010000, others 0; CALC lasts 1 cycle.
REQ-037 N=16, random b, iter_cfg=70, out_ready toggled randomly -> all 16 values match the model in order; x_out is stable during stalls.
REQ-038 Assert reset mid-CALC, then send a new problem -> the result matches the model for the new problem only.
REQ-039 Repeat REQ-035 with N=4 and N=64 -> boundary zero terms are correct and the results match the model.
